// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift on device clock, ack check.
// Define PS2_HOST_TX_RETRY_EN to retry a failed frame up to twice and expose retry_cnt.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int REQ_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       error
`ifdef PS2_HOST_TX_RETRY_EN
  ,
  output logic [1:0] retry_cnt
`endif
);

  localparam int MAX_A = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int MAX_C = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] REQ_LAST = CW'(REQ_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INHIBIT = 3'd1;
  localparam logic [2:0] S_REQ     = 3'd2;
  localparam logic [2:0] S_SHIFT   = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [3:0]    bitcnt;
  logic [7:0]    byte_q;
  logic          parity;
  logic          shift_oe;
  logic          ack;
  logic [2:0]    clk_sync;
  logic [2:0]    data_sync;
  logic          clk_last;
  logic          fall;
  logic          tmo;
  logic          idle_ok;
  logic          fail_now;

  // Synchronisers idle high so a reset never fabricates a falling edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_sync  <= 3'b111;
      data_sync <= 3'b111;
      clk_last  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[1:0], ps2_data};
      clk_last  <= clk_sync[2];
    end
  end

  assign fall = clk_last & ~clk_sync[2];

  always_comb begin
    tmo      = ((state == S_SHIFT) || (state == S_WAIT)) && (cnt == TO_LAST);
    idle_ok  = (state == S_WAIT) && clk_sync[2] && data_sync[2];
    fail_now = tmo || (idle_ok && !ack);
  end

  // Line drive is decoded from state so an async reset releases the pads at once.
  assign busy        = (state != S_IDLE);
  assign ps2_clk_oe  = (state == S_INHIBIT) || (state == S_REQ);
  assign ps2_data_oe = (state == S_REQ) || ((state == S_SHIFT) && shift_oe);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bitcnt   <= '0;
      byte_q   <= '0;
      parity   <= 1'b0;
      shift_oe <= 1'b0;
      ack      <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
      retry_cnt <= '0;
`endif
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tx_valid) begin
            byte_q <= tx_data;
            parity <= ~^tx_data;
            cnt    <= '0;
            state  <= S_INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
            retry_cnt <= '0;
`endif
          end
        end
        S_INHIBIT: begin
          if (cnt == INH_LAST) begin
            cnt   <= '0;
            state <= S_REQ;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_REQ: begin
          if (cnt == REQ_LAST) begin
            cnt      <= '0;
            bitcnt   <= '0;
            shift_oe <= 1'b1;
            state    <= S_SHIFT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_SHIFT, S_WAIT: begin
          cnt <= cnt + CW'(1);
          if (fail_now) begin
`ifdef PS2_HOST_TX_RETRY_EN
            if (retry_cnt != 2'd2) begin
              retry_cnt <= retry_cnt + 2'd1;
              cnt       <= '0;
              state     <= S_INHIBIT;
            end else begin
              error <= 1'b1;
              state <= S_IDLE;
            end
`else
            error <= 1'b1;
            state <= S_IDLE;
`endif
          end else if (idle_ok) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else if ((state == S_SHIFT) && fall) begin
            // Falls 1..8 data LSB first, 9 parity, 10 stop, 11 ack sample.
            bitcnt <= bitcnt + 4'd1;
            if (bitcnt < 4'd8) begin
              shift_oe <= ~byte_q[bitcnt[2:0]];
            end else if (bitcnt == 4'd8) begin
              shift_oe <= ~parity;
            end else if (bitcnt == 4'd9) begin
              shift_oe <= 1'b0;
            end else begin
              ack   <= ~data_sync[2];
              state <= S_WAIT;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: device model on the shared pads, per-cycle check against a timeline model.
module tb_ps2_host_tx;
  localparam int INH = 5000;
  localparam int REQ = 8;
  localparam int TO  = 2000;
`ifdef PS2_HOST_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif
  localparam int NEVER = 32'h7fff_ffff;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       clk_oe, data_oe, busy, done, error;
  logic       ps2_clk_pad, ps2_data_pad;
`ifdef PS2_HOST_TX_RETRY_EN
  logic [1:0] retry_cnt;
`endif

  assign ps2_clk_pad  = dev_clk & ~clk_oe;
  assign ps2_data_pad = dev_data & ~data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .REQ_CYCLES(REQ), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetn(resetn), .ps2_clk(ps2_clk_pad), .ps2_data(ps2_data_pad),
    .tx_valid(tx_valid), .tx_data(tx_data), .ps2_clk_oe(clk_oe), .ps2_data_oe(data_oe),
    .busy(busy), .done(done), .error(error)
`ifdef PS2_HOST_TX_RETRY_EN
    , .retry_cnt(retry_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0, errors = 0;
  bit   chk_en = 1'b0;
  // Model: one byte transaction described by its attempt start, device falls and end cycle.
  int   m_first = 0, m_acc = 0, m_end = 0, m_kind = 0, m_att = 0;
  logic [7:0] m_byte = 8'h00;
  int   fall_q[$];
  int   last_inh = 0, last_req = 0, cur_inh = 0, cur_req = 0, rel_cyc = 0, err_cyc = 0;
  logic prev_clk_oe = 1'b0;

  function automatic bit odd_par(input logic [7:0] b);
    return ($countones(b) % 2) == 0;
  endfunction

  // Expected {busy, clk_oe, data_oe, done, error} in cycle c.
  function automatic logic [4:0] model_exp(input int c);
    int  nf, k;
    logic d;
    if (c >= m_end) return {3'b000, (c == m_end) && (m_kind == 1), (c == m_end) && (m_kind == 2)};
    if (c < m_first) return 5'b00000;
    if (c < m_acc) return 5'b10000;
    k = c - m_acc;
    if (k < INH) return 5'b11000;
    if (k < INH + REQ) return 5'b11100;
    nf = 0;
    foreach (fall_q[i]) if (fall_q[i] + 4 <= c) nf++;
    if (nf == 0) d = 1'b1;
    else if (nf <= 8) d = ~m_byte[nf-1];
    else if (nf == 9) d = ~odd_par(m_byte);
    else d = 1'b0;
    return {1'b1, 1'b0, d, 2'b00};
  endfunction

  task automatic m_start(input int c, input logic [7:0] b);
    m_first = c; m_acc = c; m_end = NEVER; m_kind = 0; m_att = 0; m_byte = b;
    fall_q.delete();
  endtask

  task automatic m_finish(input int e, input bit ok);
    if (!ok && (m_att < ATTEMPTS - 1)) begin
      m_att++; m_acc = e; fall_q.delete();
    end else begin
      m_end = e; m_kind = ok ? 1 : 2;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    tx_valid = 1'b1; tx_data = b;
    m_start(cyc + 1, b);
    @(posedge clk); #1;
    tx_valid = 1'b0; tx_data = 8'($urandom);
  endtask

  // Keyboard side: clocks 11 bits with half period h, samples on rising edges, optional ACK.
  task automatic dev_frame(input bit ack, input int h, input int abort_at,
                           input logic [7:0] b, output logic [10:0] smp);
    int t;
    smp = '0;
    t = 0;
    while (!(ps2_clk_pad && !ps2_data_pad && !clk_oe) && t < 12000) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 12000) begin
      checks++; errors++;
      $display("FAIL host_release: waited %0d cycles for request-to-send, want < 12000", t);
      return;
    end
    chk("start_bit", 32'(ps2_data_pad), 32'd0);
    for (int i = 1; i <= 11; i++) begin
      repeat (h) @(posedge clk);
      #1;
      dev_clk = 1'b0;
      fall_q.push_back(cyc);
      if (i == abort_at) return;
      repeat (h) @(posedge clk);
      #1;
      if (i <= 10) smp[i-1] = ps2_data_pad;
      dev_clk = 1'b1;
      if (i == 10 && ack) dev_data = 1'b0;
    end
    if (ack) begin
      repeat (h) @(posedge clk);
      #1;
      dev_data = 1'b1;
    end
    m_finish(cyc + 4, ack);
    chk("frame_bits", 32'(smp), 32'({1'b1, odd_par(b), b}));
  endtask

  task automatic wait_end();
    int t;
    t = 0;
    while (cyc <= m_end && t < 20000) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 20000) begin
      checks++; errors++;
      $display("FAIL frame_end: no end after %0d cycles, want end at cycle %0d", t, m_end);
    end
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [10:0] smp;
    logic [7:0]  b;
    int          e, h;
    fork
      forever begin
        @(negedge clk);
        if (chk_en) begin
          logic [4:0] exp_v, act_v;
          exp_v = model_exp(cyc);
          act_v = {busy, clk_oe, data_oe, done, error};
          checks++;
          if (act_v !== exp_v) begin
            errors++;
            $display("FAIL cycle %0d {busy,clk_oe,data_oe,done,error}: got %b want %b", cyc, act_v, exp_v);
          end
        end
        if (clk_oe && !data_oe) cur_inh++;
        else if (clk_oe && data_oe) cur_req++;
        if (prev_clk_oe && !clk_oe) begin
          last_inh = cur_inh; last_req = cur_req; cur_inh = 0; cur_req = 0; rel_cyc = cyc;
        end
        if (error) err_cyc = cyc;
        prev_clk_oe = clk_oe;
      end
      begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, checks %0d", checks);
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({busy, clk_oe, data_oe, done, error}), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    chk_en = 1'b1;
    repeat (5) @(posedge clk);

    // Set-LEDs command with ACK
    send(8'hED);
    dev_frame(1'b1, 20, 0, 8'hED, smp);
    wait_end();
    chk("ED_frame", 32'(smp), 32'(11'b1_1_1110_1101));
    chk("inhibit_len", 32'(last_inh), 32'd5000);
    chk("req_len", 32'(last_req), 32'd8);

    send(8'hF4);
    dev_frame(1'b1, 15, 0, 8'hF4, smp);
    wait_end();
    chk("F4_frame", 32'(smp), 32'(11'b1_0_1111_0100));

    send(8'h00);
    dev_frame(1'b1, 12, 0, 8'h00, smp);
    wait_end();
    chk("00_frame", 32'(smp), 32'(11'b1_1_0000_0000));

    // No ACK from the device
    b = 8'($urandom);
    h = $urandom_range(30, 10);
    send(b);
    for (int a = 0; a < ATTEMPTS; a++) dev_frame(1'b0, h, 0, b, smp);
    wait_end();
`ifdef PS2_HOST_TX_RETRY_EN
    chk("retry_cnt_final", 32'(retry_cnt), 32'd2);
`endif

    // Device never clocks
    send(8'($urandom));
    for (int a = 0; a < ATTEMPTS; a++) begin
      e = m_acc + INH + REQ + TO;
      while (cyc < e) begin
        @(posedge clk); #1;
      end
      m_finish(e, 1'b0);
    end
    wait_end();
    chk("timeout_latency", 32'(err_cyc - rel_cyc), 32'd2000);

    // Reset after fall 5 while data bit 4 (0) is being driven low
    b = 8'($urandom) & 8'hEF;
    h = $urandom_range(30, 10);
    send(b);
    dev_frame(1'b1, h, 5, b, smp);
    repeat (5) @(posedge clk);
    #3;
    chk_en = 1'b0;
    resetn = 1'b0;
    #1;
    chk("rst_clk_oe", 32'(clk_oe), 32'd0);
    chk("rst_data_oe", 32'(data_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    dev_clk = 1'b1; dev_data = 1'b1;
    m_first = 0; m_acc = 0; m_end = 0; m_kind = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    chk_en = 1'b1;
    repeat (5) @(posedge clk);
    send(8'h55);
    dev_frame(1'b1, 18, 0, 8'h55, smp);
    wait_end();
    chk("55_frame", 32'(smp), 32'(11'b1_1_0101_0101));

    // tx_valid held for the whole frame, tx_data changed mid-frame
    b = 8'($urandom);
    h = $urandom_range(30, 10);
    @(posedge clk); #1;
    tx_valid = 1'b1; tx_data = b;
    m_start(cyc + 1, b);
    repeat (100) @(posedge clk);
    #1;
    tx_data = ~b;
    dev_frame(1'b1, h, 0, b, smp);
    e = 0;
    while (cyc < m_end && e < 5000) begin
      @(posedge clk); #1; e++;
    end
    tx_valid = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    chk("hold_single_frame", 32'(busy), 32'd0);

    // Random byte and device speed
    b = 8'($urandom);
    send(b);
    dev_frame(1'b1, $urandom_range(30, 10), 0, b, smp);
    wait_end();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
